// File: rtl/idm_pkg.sv
// Shared types and constants for the unified instruction/data memory controller.
// Holds the controller state encoding, the HALT fill word and the wait-counter width.
package idm_pkg;

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_IDLE = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    // HALT opcode (111) in the top bits, zero operand
    localparam logic [13:0] HALT_WORD = 14'h3800;

    localparam int WCNT_W   = 4;
    localparam int WAIT_MAX = (1 << WCNT_W) - 1;

endpackage

// File: rtl/idm_array.sv
// DEPTH x DW storage: combinational read, one synchronous write port that either
// replaces the full word (fill) or only the low WRW-bit field (request writes).
// With IDM_DEBUG_TAP_EN a second combinational read port exposes one low field.
module idm_array #(
    parameter int DW  = 14,
    parameter int AW  = 6,
    parameter int WRW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic          full_wr,
    input  logic [AW-1:0] wadr,
    input  logic [DW-1:0] wd,
    input  logic [AW-1:0] radr,
    output logic [DW-1:0] rd
`ifdef IDM_DEBUG_TAP_EN
    ,
    input  logic [AW-1:0]  tap_adr,
    output logic [WRW-1:0] tap_rd
`endif
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] wr_mask;

    // Bit lanes above WRW are only writable during the fill sequence
    generate
        for (genvar gi = 0; gi < DW; gi++) begin : g_mask
            if (gi < WRW) begin : g_low
                assign wr_mask[gi] = 1'b1;
            end else begin : g_high
                assign wr_mask[gi] = full_wr;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wadr] <= (mem[wadr] & ~wr_mask) | (wd & wr_mask);
        end
    end

    assign rd = mem[radr];

`ifdef IDM_DEBUG_TAP_EN
    assign tap_rd = mem[tap_adr][WRW-1:0];
`endif

endmodule

// File: rtl/idm_ctrl.sv
// Unified instruction/data memory controller: post-reset fill, valid/ready request port,
// configurable read wait-states. Optional debug tap enabled by macro IDM_DEBUG_TAP_EN.
module idm_ctrl
    import idm_pkg::*;
#(
    parameter int            DW       = 14,
    parameter int            AW       = 6,
    parameter int            WRW      = 8,
    parameter int            WAIT     = 1,
    parameter logic [DW-1:0] FILL     = DW'(HALT_WORD),
    parameter int            TAP_ADDR = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic           req_we,
    input  logic [AW-1:0]  req_adr,
    input  logic [WRW-1:0] req_wd,
    output logic           rsp_valid,
    output logic [DW-1:0]  rsp_rd,
    output logic           init_done
`ifdef IDM_DEBUG_TAP_EN
    ,
    output logic [WRW-1:0] dbg_tap
`endif
);

    localparam int DEPTH = 1 << AW;
    localparam logic [WCNT_W-1:0] WAIT_LAST = (WAIT == 0) ? '0 : WCNT_W'(WAIT - 1);

    generate
        if (WRW < 1 || WRW > DW) begin : g_bad_wrw
            $error("idm_ctrl: WRW must be in 1..DW");
        end
        if (WAIT < 0 || WAIT > WAIT_MAX) begin : g_bad_wait
            $error("idm_ctrl: WAIT must be in 0..15");
        end
        if (TAP_ADDR < 0 || TAP_ADDR >= DEPTH) begin : g_bad_tap
            $error("idm_ctrl: TAP_ADDR outside address space");
        end
    endgenerate

    state_t            state_reg, state_next;
    logic [AW-1:0]     cnt_reg;
    logic [WCNT_W-1:0] wcnt_reg;
    logic [AW-1:0]     adr_reg;
    logic [DW-1:0]     rsp_rd_reg;
    logic              init_done_reg;

    logic              mem_we;
    logic              full_wr;
    logic [AW-1:0]     wadr;
    logic [DW-1:0]     wdata;
    logic [AW-1:0]     rd_adr;
    logic [DW-1:0]     rd_data;
    logic              rsp_load;
    logic              rd_accept;

    always_comb begin
        state_next = state_reg;
        req_ready  = 1'b0;
        mem_we     = 1'b0;
        full_wr    = 1'b0;
        wadr       = req_adr;
        wdata      = DW'(req_wd);
        rd_adr     = adr_reg;
        rsp_load   = 1'b0;
        rd_accept  = 1'b0;
        case (state_reg)
            S_INIT: begin
                mem_we  = 1'b1;
                full_wr = 1'b1;
                wadr    = cnt_reg;
                wdata   = FILL;
                if (cnt_reg == AW'(DEPTH - 1)) begin
                    state_next = S_IDLE;
                end
            end
            S_IDLE: begin
                req_ready = 1'b1;
                // With zero wait-states the response is captured on the accepting edge
                rd_adr    = req_adr;
                if (req_valid) begin
                    if (req_we) begin
                        mem_we = 1'b1;
                    end else begin
                        rd_accept = 1'b1;
                        if (WAIT == 0) begin
                            state_next = S_RESP;
                            rsp_load   = 1'b1;
                        end else begin
                            state_next = S_WAIT;
                        end
                    end
                end
            end
            S_WAIT: begin
                if (wcnt_reg == WAIT_LAST) begin
                    state_next = S_RESP;
                    rsp_load   = 1'b1;
                end
            end
            S_RESP: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_INIT;
            cnt_reg       <= '0;
            wcnt_reg      <= '0;
            adr_reg       <= '0;
            rsp_rd_reg    <= '0;
            init_done_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_INIT) begin
                cnt_reg <= cnt_reg + AW'(1);
                if (state_next == S_IDLE) begin
                    init_done_reg <= 1'b1;
                end
            end
            if (rd_accept) begin
                adr_reg  <= req_adr;
                wcnt_reg <= '0;
            end else if (state_reg == S_WAIT) begin
                wcnt_reg <= wcnt_reg + WCNT_W'(1);
            end
            if (rsp_load) begin
                rsp_rd_reg <= rd_data;
            end
        end
    end

    assign rsp_valid = (state_reg == S_RESP);
    assign rsp_rd    = rsp_rd_reg;
    assign init_done = init_done_reg;

    idm_array #(
        .DW  (DW),
        .AW  (AW),
        .WRW (WRW)
    ) u_array (
        .clk     (clk),
        .we      (mem_we),
        .full_wr (full_wr),
        .wadr    (wadr),
        .wd      (wdata),
        .radr    (rd_adr),
        .rd      (rd_data)
`ifdef IDM_DEBUG_TAP_EN
        ,
        .tap_adr (AW'(TAP_ADDR)),
        .tap_rd  (dbg_tap)
`endif
    );

endmodule

// File: tb/tb_idm_ctrl.sv
// Scoreboard bench for idm_ctrl (WAIT=2): expected read data is queued at acceptance
// and checked by a response monitor; timing, reset and fill behaviour checked inline.
module tb_idm_ctrl;

    localparam int TB_WAIT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [5:0]  req_adr = '0;
    logic [7:0]  req_wd = '0;
    logic        rsp_valid;
    logic [13:0] rsp_rd;
    logic        init_done;
`ifdef IDM_DEBUG_TAP_EN
    logic [7:0]  dbg_tap;
`endif

    int checks = 0;
    int failures = 0;
    int rsp_cnt = 0;
    logic [13:0] exp_q[$];
    logic [13:0] model[64];

    always #5 clk = ~clk;

    idm_ctrl #(.WAIT(TB_WAIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_adr   (req_adr),
        .req_wd    (req_wd),
        .rsp_valid (rsp_valid),
        .rsp_rd    (rsp_rd),
        .init_done (init_done)
`ifdef IDM_DEBUG_TAP_EN
        ,
        .dbg_tap   (dbg_tap)
`endif
    );

    // Response monitor: every pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (!rst && rsp_valid === 1'b1) begin
            logic [13:0] e;
            rsp_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL rsp_unexpected got=%h expected=no_pulse", rsp_rd);
            end else begin
                e = exp_q.pop_front();
                if (rsp_rd !== e) begin
                    failures++;
                    $display("FAIL rsp_data got=%h expected=%h", rsp_rd, e);
                end else begin
                    $display("rsp ok data=%h", rsp_rd);
                end
            end
        end
    end

    task automatic model_fill();
        for (int i = 0; i < 64; i++) model[i] = 14'h3800;
        exp_q.delete();
    endtask

    // Returns at #1 after the edge that released reset
    task automatic apply_reset();
        rst = 1'b1;
        model_fill();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_init(input int exp_edges);
        int n;
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            #1 n++;
            if (init_done === 1'b1) break;
        end
        checks++;
        if (exp_edges > 0 ? (n != exp_edges) : (n >= 200)) begin
            failures++;
            $display("FAIL init_latency got=%0d expected=%0d", n, exp_edges);
        end else begin
            $display("init done after %0d cycles", n);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 50) begin
            failures++;
            $display("FAIL %s_ready_timeout got=%b expected=1", tag, req_ready);
        end
    endtask

    task automatic do_write(input logic [5:0] a, input logic [7:0] d);
        req_valid = 1'b1; req_we = 1'b1; req_adr = a; req_wd = d;
        wait_ready("wr");
        model[a][7:0] = d;
        $display("write adr=%0d wd=%h", a, d);
        @(posedge clk);
        #1 req_valid = 1'b0; req_we = 1'b0;
    endtask

    task automatic do_read(input logic [5:0] a);
        int cnt0;
        req_valid = 1'b1; req_we = 1'b0; req_adr = a;
        wait_ready("rd");
        exp_q.push_back(model[a]);
        cnt0 = rsp_cnt;
        $display("read adr=%0d expect=%h", a, model[a]);
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_ready("rd_done");
        checks++;
        if (rsp_cnt != cnt0 + 1) begin
            failures++;
            $display("FAIL rsp_count got=%0d expected=%0d", rsp_cnt - cnt0, 1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_fill();
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_rd, init_done, req_ready} !== 17'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%b_%h_%b_%b expected=0_0000_0_0",
                     rsp_valid, rsp_rd, init_done, req_ready);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        wait_init(64);
        do_read(6'd5);
        do_read(6'd0);
        do_read(6'd63);
    endtask

    task automatic test_write_read();
        do_write(6'd32, 8'h2E);
        do_read(6'd32);
    endtask

    task automatic test_back_to_back();
        logic [5:0] adrs[8];
        for (int i = 0; i < 8; i++) begin
            adrs[i] = (i == 0) ? 6'd0 : (i == 1) ? 6'd63 : 6'($urandom_range(0, 63));
            do_write(adrs[i], 8'($urandom));
        end
        for (int i = 0; i < 8; i++) do_read(adrs[i]);
    endtask

    task automatic test_wait_timing();
        req_valid = 1'b1; req_we = 1'b0; req_adr = 6'd5;
        wait_ready("tm");
        exp_q.push_back(model[5]);
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int i = 1; i <= TB_WAIT + 1; i++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 1'b0 || rsp_valid !== (i == TB_WAIT + 1)) begin
                failures++;
                $display("FAIL timing_k+%0d got=rdy%b_vld%b expected=rdy0_vld%0d",
                         i, req_ready, rsp_valid, (i == TB_WAIT + 1));
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL timing_k+%0d got=rdy%b_vld%b expected=rdy1_vld0",
                     TB_WAIT + 2, req_ready, rsp_valid);
        end
        $display("wait timing sequence done");
        @(posedge clk);
        #1;
    endtask

    task automatic test_init_ignore();
        int bad;
        apply_reset();
        req_valid = 1'b1; req_we = 1'b1; req_adr = 6'd7; req_wd = 8'hFF;
        bad = 0;
        for (int i = 0; i < 56; i++) begin
            @(negedge clk);
            if (req_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL init_ready got=%0d_high_cycles expected=0", bad);
        end
        @(posedge clk);
        #1 req_valid = 1'b0; req_we = 1'b0;
        wait_init(0);
        do_read(6'd7);
    endtask

    task automatic test_reset_in_wait();
        int pulses;
        do_write(6'd32, 8'h55);
        req_valid = 1'b1; req_we = 1'b0; req_adr = 6'd32;
        wait_ready("rw");
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_fill();
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL reset_drop got=%0d_pulses expected=0", pulses);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        wait_init(64);
        do_read(6'd32);
    endtask

`ifdef IDM_DEBUG_TAP_EN
    task automatic test_debug_tap();
        do_write(6'd32, 8'h63);
        @(negedge clk);
        checks++;
        if (dbg_tap !== 8'h63) begin
            failures++;
            $display("FAIL tap_after_write got=%h expected=63", dbg_tap);
        end
        @(posedge clk);
        #1;
        do_write(6'd31, 8'h11);
        @(negedge clk);
        checks++;
        if (dbg_tap !== 8'h63) begin
            failures++;
            $display("FAIL tap_other_adr got=%h expected=63", dbg_tap);
        end
        @(posedge clk);
        #1;
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_wait_timing();
        test_init_ignore();
        test_reset_in_wait();
`ifdef IDM_DEBUG_TAP_EN
        test_debug_tap();
`endif
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
